ringosc_freq_counter: RTL and testbench
=======================================

Name: ringosc_freq_counter

Overview:
Synthesizable frequency counter that consumes the ring-oscillator output (pre-divided so it is slow enough to sample) and measures its frequency digitally.
- Flow: on a start request, waits a programmable settle time (VDD step settling), counts rising edges of osc_in over a programmable window of clk cycles, then presents the count on a valid/ready output.
- Position: directly downstream of ringosc. Replaces the behavioural frequency monitor for on-chip measurement sweeps.

Parameters:
CNT_W, 16, width of edge counter / result
WIN_W, 16, width of settle_len and win_len timers
SYNC_STAGES, 2, flops in osc_in synchronizer (min 2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
osc_in  in  1  async divided oscillator signal; requirement f(osc_in) <= f(clk)/4
start  in  1  measurement request; sampled only in IDLE
settle_len  in  WIN_W  settle cycles; sampled on accepted start
win_len  in  WIN_W  count-window cycles; sampled on accepted start
busy  out  1  high in SETTLE, COUNT, DONE
count  out  CNT_W  edges counted in last window
count_valid  out  1  result available
count_ready  in  1  consumer accepts result

Behaviour:
- Reset (rst high at a clk edge): state=IDLE, busy=0, count=0, count_valid=0, timers=0, synchronizer flops and edge-history flop=0. Reset mid-operation aborts the measurement with no result.
- Synchronizer: SYNC_STAGES-flop chain on osc_in, plus a prev flop.
  - rise = sync_out & ~prev.
  - prev updates every cycle in every state, so a level already high at COUNT entry is never counted.
- FSM states: IDLE, SETTLE, COUNT, DONE.
- IDLE: when start=1, latch settle_len/win_len, clear edge counter, and go to SETTLE. If latched settle_len==0, go straight to COUNT; if win_len is also 0, go straight to DONE.
- SETTLE: lasts exactly settle_len cycles, then COUNT. Edges are ignored.
- COUNT: lasts exactly win_len cycles. Each cycle with rise=1 increments the counter; the counter saturates at 2^CNT_W-1 (no wrap). After the last COUNT cycle, load count and go to DONE.
- DONE: count_valid=1.
  - count is held stable while count_ready=0.
  - When count_valid&&count_ready, go to IDLE the next cycle, with count_valid=0 and count retaining its value.
- Latency: with start accepted at edge k, busy=1 from k+1 and count_valid=1 from cycle k+1+settle_len+win_len.
- start is ignored outside IDLE, including DONE and the handshake cycle. start in the first IDLE cycle after a handshake is accepted.
- settle_len/win_len changes after acceptance have no effect on the running measurement.

Optional Feature:
Macro RINGOSC_FREQ_CNT_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0).
  - Set when an increment is attempted at saturation during COUNT.
  - Presented with count; valid while count_valid=1; cleared on accepted start.
- Undefined: no ovf port. Saturation behaviour is unchanged.

Decomposition:
- Package ringosc_pkg: state enum typedef (IDLE/SETTLE/COUNT/DONE) and default width constants.
- One sub-module, ringosc_edge_sync: synchronizer chain plus rise detector, parameterized by SYNC_STAGES.
- FSM, timer and counter stay in the top module.

Test Plan:
- Basic count: osc_in period 8 clk (4 high/4 low), settle_len=4, win_len=80, start at cycle k, ready=1 -> count_valid at k+85, count=10, busy low at k+86.
- Zero lengths: settle_len=0, win_len=0 -> count_valid at k+1, count=0. Then settle_len=0, win_len=16, period 4 -> count=4 at k+17.
- Backpressure: hold count_ready=0 for 6 cycles after valid and pulse start during them -> count/valid stable, start ignored. Then ready=1 -> IDLE next cycle, and a new start is accepted.
- Saturation (CNT_W=4): period 4, win_len=100 -> count=15. With RINGOSC_FREQ_CNT_OVF_EN, ovf=1. Next run with win_len=20 -> count=5, ovf=0.
- Reset mid-COUNT: assert rst for 1 cycle during COUNT -> next cycle state IDLE, busy=0, count=0, count_valid=0. A fresh measurement then returns the correct count.
- osc_in held high from reset, win_len=40 -> count=0 (no spurious edge at COUNT entry).

Source files
------------

// File: rtl/ringosc_pkg.sv
// Shared types and default widths for the ring-oscillator frequency counter.
// Contents:
//   ringosc_state_e    - measurement FSM states (idle, settle, count, done)
//   CntWDefault        - default edge counter / result width
//   WinWDefault        - default settle / window timer width
//   SyncStagesDefault  - default osc_in synchronizer depth
package ringosc_pkg;

  localparam int unsigned CntWDefault       = 16;
  localparam int unsigned WinWDefault       = 16;
  localparam int unsigned SyncStagesDefault = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCount  = 2'd2,
    StDone   = 2'd3
  } ringosc_state_e;

endpackage

// File: rtl/ringosc_freq_counter_if.sv
// Result channel of the ring-oscillator frequency counter (valid/ready).
// Signals:
//   count        - edges counted in the last window
//   count_valid  - result available
//   count_ready  - consumer accepts result
//   ovf          - counter saturated during the window (only with RINGOSC_FREQ_CNT_OVF_EN)
// Modports: master (counter side), slave (consumer side).
// Optional macro: RINGOSC_FREQ_CNT_OVF_EN adds the ovf signal.
interface ringosc_freq_counter_if #(
  parameter int unsigned CNT_W = 16
);

  logic [CNT_W-1:0] count;
  logic             count_valid;
  logic             count_ready;
`ifdef RINGOSC_FREQ_CNT_OVF_EN
  logic             ovf;
`endif

  modport master (
    output count,
    output count_valid,
`ifdef RINGOSC_FREQ_CNT_OVF_EN
    output ovf,
`endif
    input  count_ready
  );

  modport slave (
    input  count,
    input  count_valid,
`ifdef RINGOSC_FREQ_CNT_OVF_EN
    input  ovf,
`endif
    output count_ready
  );

endinterface

// File: rtl/ringosc_edge_sync.sv
// Synchronizes the asynchronous divided oscillator and flags its rising edges.
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset (clears chain and edge history)
//   osc_in  - asynchronous oscillator level
//   rise    - one-cycle pulse when the synchronized level goes 0 -> 1
// SYNC_STAGES must be at least 2.
module ringosc_edge_sync
  import ringosc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic clk,
  input  logic rst,
  input  logic osc_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // prev_q tracks the synchronized level every cycle regardless of the counter's
  // state, so a level that is already high when counting begins never reads as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ringosc_freq_counter.sv
// Digital frequency counter for the divided ring-oscillator output.
// On an accepted start it waits settle_len cycles, counts rising edges of osc_in
// over win_len cycles, then offers the saturating count on a valid/ready channel.
// Ports:
//   clk         - system clock, all logic on rising edge
//   rst         - synchronous active-high reset; aborts any measurement
//   osc_in      - asynchronous divided oscillator, f(osc_in) <= f(clk)/4
//   start       - measurement request, sampled only when idle
//   settle_len  - settle cycles, latched on accepted start
//   win_len     - count-window cycles, latched on accepted start
//   busy        - high while settling, counting or holding a result
//   res         - result channel (count, count_valid, count_ready[, ovf])
// Optional macro: RINGOSC_FREQ_CNT_OVF_EN adds res.ovf, set when an edge arrives
// while the counter is already saturated; cleared on the next accepted start.
module ringosc_freq_counter
  import ringosc_pkg::*;
#(
  parameter int unsigned CNT_W       = CntWDefault,
  parameter int unsigned WIN_W       = WinWDefault,
  parameter int unsigned SYNC_STAGES = SyncStagesDefault
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   osc_in,
  input  logic                   start,
  input  logic [WIN_W-1:0]       settle_len,
  input  logic [WIN_W-1:0]       win_len,
  output logic                   busy,
  ringosc_freq_counter_if.master res
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  ringosc_state_e   state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             rise;
  logic             cnt_sat;
  logic [CNT_W-1:0] cnt_next;

  ringosc_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .osc_in (osc_in),
    .rise   (rise)
  );

  assign cnt_sat  = (cnt_q == CntMax);
  assign cnt_next = (rise && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;

  // Timer holds "cycles remaining minus one" in the current phase, so a phase of
  // length N spans exactly N cycles and zero-length phases are skipped at entry.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    count_d = count_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          win_d = win_len;
          cnt_d = '0;
          if (settle_len != '0) begin
            state_d = StSettle;
            timer_d = settle_len - 1'b1;
          end else if (win_len != '0) begin
            state_d = StCount;
            timer_d = win_len - 1'b1;
          end else begin
            state_d = StDone;
            count_d = '0;
          end
        end
      end

      StSettle: begin
        if (timer_q == '0) begin
          if (win_q != '0) begin
            state_d = StCount;
            timer_d = win_q - 1'b1;
          end else begin
            state_d = StDone;
            count_d = '0;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      StCount: begin
        cnt_d = cnt_next;
        if (timer_q == '0) begin
          state_d = StDone;
          count_d = cnt_next;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end

      StDone: begin
        if (res.count_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      timer_q <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

`ifdef RINGOSC_FREQ_CNT_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == StIdle && start) begin
      ovf_q <= 1'b0;
    end else if (state_q == StCount && rise && cnt_sat) begin
      ovf_q <= 1'b1;
    end
  end

  assign res.ovf = ovf_q;
`endif

  assign busy            = (state_q != StIdle);
  assign res.count_valid = (state_q == StDone);
  assign res.count       = count_q;

endmodule

// File: tb/tb_ringosc_freq_counter.sv
module tb_ringosc_freq_counter;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned WIN_W       = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             osc_in = 1'b0;
  logic             start = 1'b0;
  logic [WIN_W-1:0] settle_len = '0;
  logic [WIN_W-1:0] win_len = '0;
  logic             busy;

  int checks = 0;
  int failures = 0;

  // Oscillator model: 0 = held low, 1 = held high, 2 = periodic with given period/high time.
  int osc_mode = 1;
  int osc_period = 8;
  int osc_high = 4;

  ringosc_freq_counter_if #(.CNT_W(CNT_W)) res_if ();

  ringosc_freq_counter #(
    .CNT_W       (CNT_W),
    .WIN_W       (WIN_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .osc_in     (osc_in),
    .start      (start),
    .settle_len (settle_len),
    .win_len    (win_len),
    .busy       (busy),
    .res        (res_if)
  );

  always #5 clk = ~clk;

  initial begin : osc_gen
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      if (ph + 1 >= osc_period) ph = 0;
      else ph = ph + 1;
      if (osc_mode == 2) osc_in = (ph < osc_high);
      else osc_in = (osc_mode == 1);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_osc(input int mode, input int p, input int h);
    osc_mode = mode;
    osc_period = p;
    osc_high = h;
    repeat (2 * p + 6) @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle. n_edges is the number of oscillator
  // rising edges inside the window; expected count is that value saturated.
  task automatic measure(input string tag, input int s, input int w, input int n_edges,
                         input int hold);
    int lat;
    int exp_cnt;
    logic [CNT_W-1:0] held;
    exp_cnt = (n_edges > int'(CNT_MAX)) ? int'(CNT_MAX) : n_edges;
    start = 1'b1;
    settle_len = WIN_W'(s);
    win_len = WIN_W'(w);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    settle_len = WIN_W'($urandom);
    win_len = WIN_W'($urandom);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    lat = 1;
    while (res_if.count_valid !== 1'b1 && lat < s + w + 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(s + w + 1));
    check({tag, "_count"}, 32'(res_if.count), 32'(exp_cnt));
`ifdef RINGOSC_FREQ_CNT_OVF_EN
    check({tag, "_ovf"}, 32'(res_if.ovf), 32'(n_edges > int'(CNT_MAX)));
`endif
    held = res_if.count;
    if (hold > 0) begin
      res_if.count_ready = 1'b0;
      repeat (hold) begin
        start = 1'b1;
        settle_len = WIN_W'(1);
        win_len = WIN_W'(1);
        @(posedge clk);
        @(negedge clk);
      end
      check({tag, "_hold_valid"}, 32'(res_if.count_valid), 32'd1);
      check({tag, "_hold_count"}, 32'(res_if.count), 32'(exp_cnt));
      res_if.count_ready = 1'b1;
    end
    // start stays high through the handshake edge when backpressure was applied
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_valid"}, 32'(res_if.count_valid), 32'd0);
    check({tag, "_idle_count"}, 32'(res_if.count), 32'(held));
  endtask

  initial begin : main
    int p;
    int h;
    int n;
    int s;
    res_if.count_ready = 1'b1;

    // Reset with the oscillator already held high
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(res_if.count_valid), 32'd0);
    check("reset_count", 32'(res_if.count), 32'd0);
`ifdef RINGOSC_FREQ_CNT_OVF_EN
    check("reset_ovf", 32'(res_if.ovf), 32'd0);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);

    measure("hi_const", 2, 40, 0, 0);
    measure("zero_len", 0, 0, 0, 0);

    set_osc(2, 4, 2);
    measure("s0_w16", 0, 16, 4, 0);

    set_osc(2, 8, 4);
    measure("basic", 4, 80, 10, 0);
    measure("backpressure", 3, 24, 3, 6);

    set_osc(2, 4, 2);
    measure("saturate", 0, 100, 25, 0);
    measure("unsat", 2, 20, 5, 0);

    // Abort in the middle of the count window
    start = 1'b1;
    settle_len = WIN_W'(3);
    win_len = WIN_W'(60);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(res_if.count_valid), 32'd0);
    check("midrst_count", 32'(res_if.count), 32'd0);
    repeat (12) @(negedge clk);
    measure("after_rst", 1, 32, 8, 0);

    // Randomized periodic oscillators; window is a whole number of periods,
    // so exactly n rising edges land inside it whatever the phase.
    for (int i = 0; i < 10; i++) begin
      p = int'($urandom_range(4, 12));
      h = int'($urandom_range(1, p - 1));
      n = int'($urandom_range(0, 20));
      s = int'($urandom_range(0, 7));
      set_osc(2, p, h);
      repeat ($urandom_range(0, p)) @(negedge clk);
      measure($sformatf("rand%0d", i), s, p * n, n, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
